// File: rtl/approx_div_if.sv
// Operand/result handshake bundle for approx_div.
// The master drives operands and out_ready; the slave (the divider) returns the quotient.
interface approx_div_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, out, out_valid
    );
    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, out, out_valid
    );
endinterface

// File: rtl/approx_div.sv
// Iterative FP32 divider: one quotient bit per cycle by restoring division.
// Denormals flush to zero, the mantissa is truncated and the exponent saturates to 255.
module approx_div (
    input logic         en,
    input logic         rst,
    approx_div_if.slave io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] r_q, r_d, q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  in_ea, in_eb;
    logic        in_s;
    logic        ge;
    logic [24:0] q_next;
    logic        adj;
    logic [22:0] m_n;
    logic signed [9:0] e_n;

    assign in_ea = io.a[30:23];
    assign in_eb = io.b[30:23];
    assign in_s  = io.a[31] ^ io.b[31];

    assign io.in_ready  = (state_q == IDLE);
    assign io.out       = out_q;
    assign io.out_valid = out_valid_q;

    always_ff @(posedge en) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            mb_q        <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            mb_q        <= mb_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // One restoring step plus the normalization used on the final step.
    always_comb begin
        ge            = (r_q >= {1'b0, mb_q});
        q_next        = q_q;
        q_next[cnt_q] = ge;
        adj           = ~q_next[24];
        m_n           = q_next[24] ? q_next[23:1] : q_next[22:0];
        e_n           = 10'(ea_q) - 10'(eb_q) + 10'd127 - 10'(adj);
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        mb_d        = mb_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    s_d  = in_s;
                    ea_d = in_ea;
                    eb_d = in_eb;
                    if (in_ea == 8'hFF || in_eb == 8'hFF || in_eb == 8'h00) begin
                        out_d       = {in_s, 8'hFF, 23'h0};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (in_ea == 8'h00) begin
                        out_d       = {in_s, 8'h00, 23'h0};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mb_d    = {1'b1, io.b[22:0]};
                        r_d     = {2'b01, io.a[22:0]};
                        q_d     = '0;
                        cnt_d   = 5'd24;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d = ge ? (r_q - {1'b0, mb_q}) << 1 : r_q << 1;
                q_d = q_next;
                if (cnt_q == 5'd0) begin
                    if (e_n >= 10'sd255)
                        out_d = {s_q, 8'hFF, 23'h0};
                    else if (e_n <= 10'sd0)
                        out_d = {s_q, 8'h00, 23'h0};
                    else
                        out_d = {s_q, e_n[7:0], m_n};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_approx_div.sv
// Self-checking bench for approx_div: vector table through a scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_approx_div;
    logic en = 1'b0;
    logic rst = 1'b0;
    approx_div_if io();
    approx_div dut (.en(en), .rst(rst), .io(io));

    always #5 en = ~en;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operand pair with out_ready high; check latency, result and 1-cycle valid.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int n;
        logic [31:0] e;
        @(negedge en);
        io.a = a; io.b = b; io.in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge en); #1;
        io.in_valid = 1'b0;
        io.a = 32'hDEADBEEF; io.b = 32'h12345678;
        chk({name, "_in_ready_low"}, 32'(io.in_ready), 32'd0);
        n = 1;
        while (!io.out_valid && n < 40) begin
            @(posedge en); #1;
            n++;
        end
        chk({name, "_latency"}, n, lat);
        if (io.out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_out"}, io.out, e);
        end
        @(posedge en); #1;
        chk({name, "_valid_fall"}, 32'(io.out_valid), 32'd0);
        chk({name, "_in_ready_back"}, 32'(io.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 26, "six_div_two"};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, "one_div_three"};
        vecs[2] = '{32'hC1000000, 32'h3F000000, 32'hC1800000, 26, "neg8_div_half"};
        vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1,  "div_by_zero"};
        vecs[4] = '{32'h00000000, 32'h40000000, 32'h00000000, 1,  "zero_div"};
        vecs[5] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1,  "ninf_div"};
        vecs[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 26, "overflow"};
        vecs[7] = '{32'h00800000, 32'h7F000000, 32'h00000000, 26, "underflow"};
        vecs[8] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800000, 26, "equal_ops"};
        vecs[9] = '{32'h40000000, 32'hBF400000, 32'hC02AAAAA, 26, "two_div_neg075"};

        io.a = '0; io.b = '0; io.in_valid = 1'b0; io.out_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge en);
        #1;
        chk("reset_in_ready", 32'(io.in_ready), 32'd1);
        chk("reset_out_valid", 32'(io.out_valid), 32'd0);
        chk("reset_out", io.out, 32'h0);
        @(negedge en); rst = 1'b1;

        foreach (vecs[i])
            do_div(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // Backpressure: result must hold while the consumer stalls.
        @(negedge en);
        io.out_ready = 1'b0;
        io.a = 32'h40C00000; io.b = 32'h40000000; io.in_valid = 1'b1;
        @(posedge en); #1;
        io.in_valid = 1'b0;
        n = 1;
        while (!io.out_valid && n < 40) begin
            @(posedge en); #1;
            n++;
        end
        chk("bp_latency", n, 26);
        held = io.out;
        chk("bp_out", held, 32'h40400000);
        for (int c = 0; c < 10; c++) begin
            @(negedge en);
            if (c == 3) begin
                io.a = 32'h3F800000; io.b = 32'h00000000; io.in_valid = 1'b1;
            end else begin
                io.in_valid = 1'b0;
            end
            @(posedge en); #1;
            chk($sformatf("bp_hold_out_%0d", c), io.out, 32'h40400000);
            chk($sformatf("bp_hold_valid_%0d", c), 32'(io.out_valid), 32'd1);
            chk($sformatf("bp_hold_in_ready_%0d", c), 32'(io.in_ready), 32'd0);
        end
        @(negedge en);
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge en); #1;
        chk("bp_release_valid", 32'(io.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(io.in_ready), 32'd1);
        chk("bp_release_out_kept", io.out, 32'h40400000);

        // Reset at cycle 10 of a divide discards it.
        @(negedge en);
        io.a = 32'h3F800000; io.b = 32'h40400000; io.in_valid = 1'b1;
        @(posedge en); #1;
        io.in_valid = 1'b0;
        repeat (8) @(posedge en);
        @(negedge en); rst = 1'b0;
        @(posedge en); #1;
        chk("midreset_out", io.out, 32'h0);
        chk("midreset_out_valid", 32'(io.out_valid), 32'd0);
        chk("midreset_in_ready", 32'(io.in_ready), 32'd1);
        @(negedge en); rst = 1'b1;
        repeat (30) begin
            @(posedge en); #1;
            if (io.out_valid) begin
                checks++; errors++;
                $display("FAIL midreset_stale_valid: got out_valid 1 expected 0");
            end
        end
        do_div(32'h40C00000, 32'h40000000, 32'h40400000, 26, "after_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
